// File: rtl/leaf_bank_ctrl.sv
// leaf_bank_ctrl: leaf storage for the k-d tree ANN search.
// A streaming loader fills NUM_LEAVES x LEAF_SIZE packed entries in order.
// Once the load completes, NUM_RD_PORTS engines each fetch a whole leaf per
// cycle through registered output ports.
module leaf_bank_ctrl #(
  parameter int DATA_WIDTH   = 11,
  parameter int IDX_WIDTH    = 9,
  parameter int PATCH_SIZE   = 5,
  parameter int LEAF_SIZE    = 8,
  parameter int NUM_LEAVES   = 64,
  parameter int NUM_RD_PORTS = 2,
  localparam int LEAF_ADDRW  = $clog2(NUM_LEAVES),
  localparam int ENTRY_W     = PATCH_SIZE * DATA_WIDTH + IDX_WIDTH
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               load_start,
  input  logic                                               wr_valid,
  output logic                                               wr_ready,
  input  logic [ENTRY_W-1:0]                                 wr_entry,
  output logic                                               load_done,
  output logic [LEAF_ADDRW-1:0]                              load_leaf,
  input  logic [NUM_RD_PORTS-1:0]                            rd_req,
  input  logic [NUM_RD_PORTS*LEAF_ADDRW-1:0]                 rd_addr,
  output logic [NUM_RD_PORTS-1:0]                            rd_valid,
  output logic [NUM_RD_PORTS*LEAF_SIZE*PATCH_SIZE*DATA_WIDTH-1:0] rd_patch,
  output logic [NUM_RD_PORTS*LEAF_SIZE*IDX_WIDTH-1:0]        rd_idx
);

  localparam int SLOT_W  = $clog2(LEAF_SIZE);
  localparam int PATCH_W = PATCH_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  state_t              state;
  logic [SLOT_W-1:0]   slot;
  logic                xfer;
  logic                last_slot;
  logic                last_leaf;
  logic [NUM_RD_PORTS-1:0] rd_acc;

  logic [ENTRY_W-1:0] mem [NUM_LEAVES][LEAF_SIZE];

  // A restart in LOAD discards any entry offered in the same cycle.
  assign xfer      = wr_valid && wr_ready && !load_start;
  assign last_slot = (slot == SLOT_W'(LEAF_SIZE - 1));
  assign last_leaf = (load_leaf == LEAF_ADDRW'(NUM_LEAVES - 1));

  // Load sequencer: state, fill counters and registered handshake outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ready  <= 1'b0;
      load_done <= 1'b0;
      slot      <= '0;
      load_leaf <= '0;
    end else if (load_start) begin
      state     <= S_LOAD;
      wr_ready  <= 1'b1;
      load_done <= 1'b0;
      slot      <= '0;
      load_leaf <= '0;
    end else if (xfer) begin
      if (last_slot) begin
        slot      <= '0;
        load_leaf <= load_leaf + LEAF_ADDRW'(1);
        if (last_leaf) begin
          state     <= S_READY;
          wr_ready  <= 1'b0;
          load_done <= 1'b1;
        end
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

  // Entry storage written in load order.
  // NOTE: the storage array has no reset; its contents are only meaningful
  // after a completed load, and resetting it would cost a flop-clear tree.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[load_leaf][slot] <= wr_entry;
    end
  end

  // Read acceptance: only in READY, and a concurrent load_start wins.
  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    rd_acc = '0;
    if (state == S_READY && !load_start) begin
      rd_acc = rd_req;
    end
  end

  // Per-port read registers: a whole leaf is captured on each accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= '0;
      rd_patch <= '0;
      rd_idx   <= '0;
    end else begin
      rd_valid <= rd_acc;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_acc[p]) begin
          for (int s = 0; s < LEAF_SIZE; s++) begin
            rd_patch[(p*LEAF_SIZE+s)*PATCH_W +: PATCH_W] <=
              mem[rd_addr[p*LEAF_ADDRW +: LEAF_ADDRW]][s][PATCH_W-1:0];
            rd_idx[(p*LEAF_SIZE+s)*IDX_WIDTH +: IDX_WIDTH] <=
              mem[rd_addr[p*LEAF_ADDRW +: LEAF_ADDRW]][s][ENTRY_W-1 -: IDX_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_bank_ctrl.sv
// Directed testbench for leaf_bank_ctrl with default parameters.
module tb_leaf_bank_ctrl;

  localparam int DW      = 11;
  localparam int IW      = 9;
  localparam int PS      = 5;
  localparam int LS      = 8;
  localparam int NL      = 64;
  localparam int NP      = 2;
  localparam int AW      = 6;
  localparam int PW      = PS * DW;
  localparam int EW      = PW + IW;
  localparam int N_ENT   = NL * LS;

  logic                 clk;
  logic                 rst_n;
  logic                 load_start;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [EW-1:0]        wr_entry;
  logic                 load_done;
  logic [AW-1:0]        load_leaf;
  logic [NP-1:0]        rd_req;
  logic [NP*AW-1:0]     rd_addr;
  logic [NP-1:0]        rd_valid;
  logic [NP*LS*PW-1:0]  rd_patch;
  logic [NP*LS*IW-1:0]  rd_idx;

  int total = 0;
  int bad   = 0;

  leaf_bank_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_entry   (wr_entry),
    .load_done  (load_done),
    .load_leaf  (load_leaf),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_patch   (rd_patch),
    .rd_idx     (rd_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data set 0: idx = n, every element = n. Data set 1: idx = 511-n, element = n+1024.
  function automatic logic [IW-1:0] exp_idx(input int gen, input int n);
    return (gen == 0) ? IW'(n) : IW'(511 - n);
  endfunction

  function automatic logic [PW-1:0] exp_patch(input int gen, input int n);
    logic [DW-1:0] e;
    e = (gen == 0) ? DW'(n) : DW'(n + 1024);
    return {PS{e}};
  endfunction

  task automatic check_leaf(input int p, input int leaf, input int gen);
    for (int s = 0; s < LS; s++) begin
      check($sformatf("p%0d_leaf%0d_s%0d_patch", p, leaf, s),
            64'(rd_patch[(p*LS+s)*PW +: PW]), 64'(exp_patch(gen, leaf*LS + s)));
      check($sformatf("p%0d_leaf%0d_s%0d_idx", p, leaf, s),
            64'(rd_idx[(p*LS+s)*IW +: IW]), 64'(exp_idx(gen, leaf*LS + s)));
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    wr_valid   = 1'b0;
    tick();
    load_start = 1'b0;
    check("start_wr_ready", 64'(wr_ready), 64'd1);
    check("start_load_leaf", 64'(load_leaf), 64'd0);
    check("start_load_done", 64'(load_done), 64'd0);
  endtask

  // Streams entries [first, last) of data set gen; gaps inserts an idle cycle
  // before every transfer.
  task automatic stream(input int gen, input int first, input int last, input bit gaps);
    for (int n = first; n < last; n++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        tick();
      end
      wr_valid = 1'b1;
      wr_entry = {exp_idx(gen, n), exp_patch(gen, n)};
      if (n == 40) rd_req = 2'b11;
      if (n == 46) rd_req = 2'b00;
      if (n == 31) check("leaf_during_xfer32", 64'(load_leaf), 64'd3);
      if (n == N_ENT - 1) check("done_before_last", 64'(load_done), 64'd0);
      tick();
      if (n == 31) check("leaf_after_xfer32", 64'(load_leaf), 64'd4);
      if (n == 45) check("rd_valid_in_load", 64'(rd_valid), 64'd0);
      if (n == 300) check("done_mid_load", 64'(load_done), 64'd0);
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_entry   = '0;
    rd_req     = '0;
    rd_addr    = '0;
    #12;
    check("rst_wr_ready", 64'(wr_ready), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_load_leaf", 64'(load_leaf), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_patch_nz", 64'(|rd_patch), 64'd0);
    check("rst_rd_idx_nz", 64'(|rd_idx), 64'd0);
    rst_n = 1'b1;
    tick();

    // Reads in IDLE are dropped.
    rd_req = 2'b11;
    tick();
    check("idle_rd_valid", 64'(rd_valid), 64'd0);
    check("idle_rd_patch_nz", 64'(|rd_patch), 64'd0);
    rd_req = 2'b00;

    // Full continuous load: load_done appears in cycle 513 after load_start.
    start_load();
    stream(0, 0, N_ENT, 1'b0);
    check("load0_done", 64'(load_done), 64'd1);
    check("load0_wr_ready", 64'(wr_ready), 64'd0);

    // Port 0 reads leaf 5.
    rd_req  = 2'b01;
    rd_addr = {AW'(0), AW'(5)};
    tick();
    rd_req = 2'b00;
    check("rd5_valid", 64'(rd_valid), 64'b01);
    check_leaf(0, 5, 0);
    tick();
    check("rd5_valid_pulse", 64'(rd_valid), 64'b00);
    check_leaf(0, 5, 0);

    // Dual-port reads: leaf 0 / leaf 63, then both leaf 17.
    rd_req  = 2'b11;
    rd_addr = {AW'(63), AW'(0)};
    tick();
    check("dual_a_valid", 64'(rd_valid), 64'b11);
    check_leaf(0, 0, 0);
    check_leaf(1, 63, 0);
    rd_addr = {AW'(17), AW'(17)};
    tick();
    rd_req = 2'b00;
    check("dual_b_valid", 64'(rd_valid), 64'b11);
    check_leaf(0, 17, 0);
    check_leaf(1, 17, 0);
    tick();
    check("dual_end_valid", 64'(rd_valid), 64'b00);

    // load_start wins over a read issued in the same READY cycle.
    rd_req     = 2'b11;
    rd_addr    = {AW'(3), AW'(3)};
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    rd_req     = 2'b00;
    check("ls_rd_valid", 64'(rd_valid), 64'b00);
    check("ls_load_done", 64'(load_done), 64'd0);
    check("ls_wr_ready", 64'(wr_ready), 64'd1);
    check_leaf(0, 17, 0);
    check_leaf(1, 17, 0);

    // 100 transfers, then a restart and a full gapped load of new data.
    stream(0, 0, 100, 1'b0);
    check("partial_leaf", 64'(load_leaf), 64'd12);
    start_load();
    stream(1, 0, N_ENT, 1'b1);
    check("load1_done", 64'(load_done), 64'd1);
    rd_req  = 2'b11;
    rd_addr = {AW'(12), AW'(0)};
    tick();
    check("new_a_valid", 64'(rd_valid), 64'b11);
    check_leaf(0, 0, 1);
    check_leaf(1, 12, 1);
    rd_addr = {AW'(63), AW'(5)};
    tick();
    rd_req = 2'b00;
    check_leaf(0, 5, 1);
    check_leaf(1, 63, 1);

    // Asynchronous reset in the middle of a load at leaf 30.
    start_load();
    stream(0, 0, 240, 1'b0);
    check("pre_rst_leaf", 64'(load_leaf), 64'd30);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wr_ready", 64'(wr_ready), 64'd0);
    check("arst_load_done", 64'(load_done), 64'd0);
    check("arst_rd_valid", 64'(rd_valid), 64'd0);
    check("arst_load_leaf", 64'(load_leaf), 64'd0);
    check("arst_rd_patch_nz", 64'(|rd_patch), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    rd_req  = 2'b11;
    rd_addr = {AW'(1), AW'(1)};
    tick();
    rd_req = 2'b00;
    check("post_rst_rd_valid", 64'(rd_valid), 64'd0);
    check("post_rst_rd_idx_nz", 64'(|rd_idx), 64'd0);
    check("post_rst_wr_ready", 64'(wr_ready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
